// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone single-master to NUM_SLAVES address-decoded slave mux.
// Optional slave-ack timeout is enabled by defining WB_SLAVE_MUX_TIMEOUT_EN.
module wb_slave_mux #(
    parameter int NUM_SLAVES = 2,
    parameter int SLAVE_AW   = 4,
    parameter int DW         = 8,
    parameter int TIMEOUT    = 255,
    localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int AW        = SEL_W + SLAVE_AW
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [AW-1:0]            wb_adr_i,
    input  logic [DW-1:0]            wb_dat_i,
    output logic [DW-1:0]            wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [SLAVE_AW-1:0]      s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("wb_slave_mux: illegal NUM_SLAVES or TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SEL_W:0] NS_LIM = (SEL_W+1)'(NUM_SLAVES);

    state_t                  state;
    logic [SEL_W-1:0]        sel_q;
    logic [DW-1:0]           rd_q;
    logic                    hold;
    logic [SEL_W-1:0]        req_sel;
    logic [NUM_SLAVES-1:0]   req_oh;
    logic                    in_range;
    logic                    ack_sel;
    logic [DW-1:0]           rd_sel;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    localparam logic [7:0]   TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]              cnt;
`endif

    always_comb begin
        req_sel  = wb_adr_i[AW-1:SLAVE_AW];
        in_range = ({1'b0, req_sel} < NS_LIM);
        req_oh   = '0;
        ack_sel  = 1'b0;
        rd_sel   = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            req_oh[k] = (req_sel == SEL_W'(k));
            if (sel_q == SEL_W'(k)) begin
                ack_sel = s_ack_i[k];
                rd_sel  = s_dat_i[k*DW +: DW];
            end
        end
    end

    // hold blocks recapture of a strobe that is still asserted after its ack/err.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            rd_q     <= '0;
            hold     <= 1'b0;
            s_cyc_o  <= '0;
            s_stb_o  <= '0;
            s_we_o   <= 1'b0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            if (!(wb_cyc_i && wb_stb_i)) hold <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i && !hold) begin
                        sel_q   <= req_sel;
                        s_adr_o <= wb_adr_i[SLAVE_AW-1:0];
                        s_we_o  <= wb_we_i;
                        s_dat_o <= wb_dat_i;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
                        cnt     <= '0;
`endif
                        if (in_range) begin
                            s_cyc_o <= req_oh;
                            s_stb_o <= req_oh;
                            state   <= BUSY;
                        end else begin
                            wb_err_o <= 1'b1;
                            wb_dat_o <= '1;
                            hold     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (!wb_cyc_i) begin
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        state   <= DONE;
                    end else if (ack_sel) begin
                        s_cyc_o  <= '0;
                        s_stb_o  <= '0;
                        wb_ack_o <= 1'b1;
                        if (!s_we_o) begin
                            rd_q     <= rd_sel;
                            wb_dat_o <= rd_sel;
                        end
                        hold  <= 1'b1;
                        state <= DONE;
                    end
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        s_cyc_o  <= '0;
                        s_stb_o  <= '0;
                        wb_err_o <= 1'b1;
                        wb_dat_o <= '1;
                        hold     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    wb_dat_o <= rd_q;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - Directed scoreboard bench for wb_slave_mux (3 slaves, TIMEOUT=4).
module tb_wb_slave_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [5:0]  adr = '0;
    logic [7:0]  dat_w = '0;
    logic [7:0]  dat_r;
    logic        ack, err;
    logic [2:0]  s_cyc, s_stb;
    logic        s_we;
    logic [3:0]  s_adr;
    logic [7:0]  s_dat;
    logic [23:0] s_rdata = '0;
    logic [2:0]  s_ack = '0;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [7:0] data;
        int         lat;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_cnt = 0;
    int    t0 = 0;

    wb_slave_mux #(.NUM_SLAVES(3), .SLAVE_AW(4), .DW(8), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
        .wb_ack_o(ack), .wb_err_o(err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat),
        .s_dat_i(s_rdata), .s_ack_i(s_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic w, input logic [5:0] a, input logic [7:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        t0 = cyc_cnt;
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic expect_resp(input logic a, input logic e, input logic [7:0] d, input int lat);
        resp_t r;
        r.ack = a; r.err = e; r.data = d; r.lat = lat;
        sb.push_back(r);
    endtask

    task automatic wait_resp(input string tag, input int max_cycles);
        resp_t r;
        logic  got;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (ack || err) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " responded"}, got, 1'b1);
        chk({tag, " sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (got && sb.size() != 0) begin
            r = sb.pop_front();
            chk({tag, " ack"}, ack, r.ack);
            chk({tag, " err"}, err, r.err);
            chk({tag, " data"}, dat_r, r.data);
            chk({tag, " latency"}, cyc_cnt - t0, r.lat);
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst s_cyc", s_cyc, 3'b000);
        chk("rst s_stb", s_stb, 3'b000);
        chk("rst s_we", s_we, 1'b0);
        chk("rst s_adr", s_adr, 4'h0);
        chk("rst s_dat", s_dat, 8'h00);
        chk("rst dat_r", dat_r, 8'h00);
        chk("rst ack", ack, 1'b0);
        chk("rst err", err, 1'b0);

        // read 0x13, slave1 acks one cycle after strobe; capture on first edge after release
        rst_n = 1'b1;
        expect_resp(1'b1, 1'b0, 8'hA5, 2);
        start(1'b0, 6'h13, 8'h00);
        tick();
        chk("rd1 s_stb", s_stb, 3'b010);
        chk("rd1 s_cyc", s_cyc, 3'b010);
        chk("rd1 s_adr", s_adr, 4'h3);
        chk("rd1 s_we", s_we, 1'b0);
        s_ack = 3'b010; s_rdata[15:8] = 8'hA5;
        wait_resp("rd1", 8);
        chk("rd1 excl", ack & err, 1'b0);
        chk("rd1 stb drop", s_stb, 3'b000);
        s_ack = 3'b000;
        drop();
        tick();
        chk("rd1 ack single", ack, 1'b0);
        chk("rd1 dat hold", dat_r, 8'hA5);

        // write 0x02 data 0x5C, slave0 acks after 3 cycles
        expect_resp(1'b1, 1'b0, 8'hA5, 4);
        start(1'b1, 6'h02, 8'h5C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr s_stb", s_stb, 3'b001);
            chk("wr s_we", s_we, 1'b1);
            chk("wr s_dat", s_dat, 8'h5C);
            chk("wr s_adr", s_adr, 4'h2);
            chk("wr early ack", ack, 1'b0);
        end
        s_ack = 3'b001;
        wait_resp("wr", 8);
        s_ack = 3'b000;
        drop();
        tick();
        chk("wr ack single", ack, 1'b0);
        chk("wr err", err, 1'b0);

        // out-of-range select 3
        expect_resp(1'b0, 1'b1, 8'hFF, 1);
        start(1'b0, 6'h35, 8'h00);
        wait_resp("oor", 4);
        chk("oor s_stb", s_stb, 3'b000);
        chk("oor s_cyc", s_cyc, 3'b000);
        tick();
        chk("oor err one cycle", err, 1'b0);
        chk("oor dat restore", dat_r, 8'hA5);
        chk("oor no recapture", s_stb, 3'b000);
        drop();
        tick();

        // spurious unselected ack, then held strobe past ack
        expect_resp(1'b1, 1'b0, 8'h3C, 3);
        start(1'b0, 6'h25, 8'h00);
        tick();
        chk("sp s_stb", s_stb, 3'b100);
        chk("sp s_adr", s_adr, 4'h5);
        s_ack = 3'b001; s_rdata[7:0] = 8'hEE;
        tick();
        chk("sp ignored ack", ack, 1'b0);
        chk("sp still busy", s_stb, 3'b100);
        s_ack = 3'b100; s_rdata[23:16] = 8'h3C;
        wait_resp("sp", 8);
        s_ack = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held stb no access", s_stb, 3'b000);
            chk("held stb no ack", ack, 1'b0);
        end
        drop();
        tick();

        // abort by dropping cyc during BUSY
        start(1'b0, 6'h11, 8'h00);
        tick();
        chk("abort s_stb", s_stb, 3'b010);
        drop();
        tick();
        chk("abort stb drop", s_stb, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no ack", ack, 1'b0);
            chk("abort no err", err, 1'b0);
        end

        // reset mid-transfer
        start(1'b0, 6'h04, 8'h00);
        tick();
        chk("rstmid s_stb", s_stb, 3'b001);
        #2;
        rst_n = 1'b0;
        drop();
        #1;
        chk("rstmid async stb", s_stb, 3'b000);
        chk("rstmid async cyc", s_cyc, 3'b000);
        tick();
        chk("rstmid dat", dat_r, 8'h00);
        rst_n = 1'b1;
        s_ack = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid no ack", ack, 1'b0);
            chk("rstmid no err", err, 1'b0);
            chk("rstmid idle stb", s_stb, 3'b000);
        end
        s_ack = 3'b000;
        expect_resp(1'b1, 1'b0, 8'h77, 2);
        start(1'b0, 6'h14, 8'h00);
        tick();
        chk("post rst s_stb", s_stb, 3'b010);
        s_ack = 3'b010; s_rdata[15:8] = 8'h77;
        wait_resp("post rst", 8);
        s_ack = 3'b000;
        drop();
        tick();

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
        // slave never acks: err after 4 BUSY cycles
        expect_resp(1'b0, 1'b1, 8'hFF, 5);
        start(1'b0, 6'h10, 8'h00);
        wait_resp("tmo", 10);
        chk("tmo stb drop", s_stb, 3'b000);
        drop();
        tick();
        chk("tmo err one cycle", err, 1'b0);
        // ack arriving exactly at the limit wins
        expect_resp(1'b1, 1'b0, 8'h5A, 5);
        s_rdata[15:8] = 8'h5A;
        start(1'b0, 6'h10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo2 no early resp", ack | err, 1'b0);
        end
        s_ack = 3'b010;
        wait_resp("tmo2", 4);
        s_ack = 3'b000;
        drop();
        tick();
        chk("tmo2 no err", err, 1'b0);
`else
        // without timeout the mux waits indefinitely for the slave
        start(1'b0, 6'h10, 8'h00);
        repeat (10) tick();
        chk("notmo still busy", s_stb, 3'b010);
        chk("notmo no err", err, 1'b0);
        drop();
        tick();
        chk("notmo abort drop", s_stb, 3'b000);
        tick();
`endif

        chk("sb drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_slave_mux.md
WB_SLAVE_MUX -- requirements
Module: wb_slave_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 2: number of slave ports, legal 1..8.
REQ-002 SHALL have parameter SLAVE_AW, default 4: per-slave address width.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles to wait for slave ack, legal 1..255.
REQ-005 SHALL derive SEL_W = max(1, clog2(NUM_SLAVES)) and AW = SEL_W + SLAVE_AW.
REQ-006 Ports:
- wb_clk_i  in  1  sole clock; all state on its rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  master cycle.
- wb_stb_i  in  1  master strobe.
- wb_we_i  in  1  master write enable.
- wb_adr_i  in  AW  master address; [AW-1:SLAVE_AW] selects slave, [SLAVE_AW-1:0] is the slave offset.
- wb_dat_i  in  DW  master write data.
- wb_dat_o  out  DW  read data to master.
- wb_ack_o  out  1  transfer complete.
- wb_err_o  out  1  transfer failed.
- s_cyc_o  out  NUM_SLAVES  per-slave cycle.
- s_stb_o  out  NUM_SLAVES  per-slave strobe.
- s_we_o  out  1  shared write enable.
- s_adr_o  out  SLAVE_AW  shared offset.
- s_dat_o  out  DW  shared write data.
- s_dat_i  in  NUM_SLAVES*DW  slave read data; slave k at [k*DW +: DW].
- s_ack_i  in  NUM_SLAVES  slave acks.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-008 IDLE: when wb_cyc_i && wb_stb_i, SHALL register the select field, offset, wb_we_i and wb_dat_i.
REQ-009 IDLE: if select < NUM_SLAVES, SHALL go to BUSY; otherwise SHALL go to DONE with wb_err_o=1 and wb_dat_o=all-ones for exactly one cycle.
REQ-010 BUSY: SHALL drive s_cyc_o[sel] and s_stb_o[sel] high, all other bits low, and s_we_o/s_adr_o/s_dat_o from the registered values (stable throughout BUSY).
REQ-011 BUSY: on s_ack_i[sel], SHALL drop s_stb_o/s_cyc_o the next cycle, register s_dat_i of sel into wb_dat_o (writes: hold previous value), pulse wb_ack_o for one cycle, and go to DONE.
REQ-012 SHALL ignore s_ack_i bits of unselected slaves in all states.
REQ-013 Latency: wb_ack_o SHALL assert exactly one cycle after the sampled s_ack_i[sel]; minimum strobe-to-ack is 2 cycles.
REQ-014 DONE: SHALL ignore wb_stb_i for one cycle, then return to IDLE, so a strobe held through ack is not recaptured.
REQ-015 SHALL never assert wb_ack_o and wb_err_o in the same cycle.
REQ-016 SHALL ignore master inputs outside IDLE; a strobe arriving during BUSY/DONE is not queued.
REQ-017 If wb_cyc_i falls during BUSY, SHALL abort: drop slave strobes the next cycle, give no ack/err, and go to DONE.
REQ-018 Each ack/err SHALL drive wb_dat_o for that cycle only; wb_dat_o SHALL hold between transfers.

Reset
REQ-019 When wb_rst_n is low, SHALL asynchronously force: state=IDLE, s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, timeout counter=0.
REQ-020 Reset asserted mid-transfer SHALL drop all strobes immediately and give no ack or err after release.
REQ-021 Release SHALL take effect on the first wb_clk_i edge with wb_rst_n high.

Configuration
REQ-022 With macro WB_SLAVE_MUX_TIMEOUT_EN defined, SHALL count BUSY cycles from 0.
- If the count reaches TIMEOUT without s_ack_i[sel], SHALL drop strobes, pulse wb_err_o for one cycle with wb_dat_o=all-ones, and go to DONE.
- An ack sampled in the same cycle the count hits TIMEOUT SHALL win: ack, no err.
REQ-023 Without WB_SLAVE_MUX_TIMEOUT_EN, SHALL omit the counter and stay in BUSY until ack or wb_cyc_i falls; wb_err_o then asserts only for out-of-range select.

Verification
REQ-024 NUM_SLAVES=2, read addr 0x13, slave1 acks 1 cycle after strobe with 0xA5 -> only s_stb_o[1] high, s_adr_o=3, wb_ack_o at strobe+2, wb_dat_o=0xA5.
REQ-025 Write addr 0x02 data 0x5C, slave0 acks after 3 cycles -> s_we_o=1, s_dat_o=0x5C stable for 3 cycles, single wb_ack_o, wb_err_o=0.
REQ-026 NUM_SLAVES=3, access select=3 -> no s_stb_o, wb_err_o one cycle, wb_dat_o=0xFF.
REQ-027 TIMEOUT_EN, TIMEOUT=4, slave never acks -> wb_err_o at cycle 4 of BUSY, strobes drop; with ack exactly at count 4 -> ack only.
REQ-028 Master holds wb_stb_i 5 cycles past ack -> exactly one slave access; unselected slave acks spuriously -> ignored.
REQ-029 wb_rst_n low during BUSY -> s_stb_o=0 immediately; no ack/err after release; next access works normally.
